multi_beam_thresh: RTL and testbench
====================================

// Module: multi_beam_thresh
// PURPOSE
//  Parametrised N-beam threshold trigger for the beamformer back end.
//  - Per beam: sums two IN_WIDTH unsigned inputs, forms a running sum over the last WINDOW samples,
//    and compares it exclusively against a per-beam threshold.
//  - Thresholds are written individually into a staging bank; a common update copies all of them
//    to the active bank in one cycle.
//  - An optional per-beam holdoff limits the trigger rate.
//  - Sits between the beam adders and the trigger combiner.
// PARAMETERS
//  NBEAMS        2    number of beams (>=1)
//  IN_WIDTH      17   unsigned width of each beam input
//  THRESH_WIDTH  18   unsigned threshold width (<= WSUM_WIDTH)
//  WINDOW        2    samples summed per beam (>=1; 2 = T + T*z^-1)
//  HOLDOFF       0    cycles a beam's trigger is suppressed after firing (0 = free-running compare)
//  derived: AW = max(1,$clog2(NBEAMS)), WSUM_WIDTH = IN_WIDTH+1+$clog2(WINDOW)
// PORTS
//  clk_i          in   1                 clock
//  rst_ni         in   1                 reset, asynchronous, active-low
//  beam_in0_i     in   NBEAMS*IN_WIDTH   first input per beam; beam b at [b*IN_WIDTH +: IN_WIDTH]
//  beam_in1_i     in   NBEAMS*IN_WIDTH   second input per beam, same packing
//  thresh_i       in   THRESH_WIDTH      threshold write data
//  thresh_addr_i  in   AW                beam index for the threshold write
//  thresh_wr_i    in   1                 write thresh_i into staging[thresh_addr_i]
//  update_i       in   1                 copy every staging entry into the active bank
//  trigger_o      out  NBEAMS            registered trigger, one bit per beam
// BEHAVIOUR
//  Reset (async assert, sync release)
//  - trigger_o = 0; staging and active thresholds = all ones; sum/window regs = 0; holdoff counters = 0.
//  - Reset mid-operation discards window history; window refills from zeros after release.
//  Datapath, all stages registered; latency 3 edges
//  - edge n:   S[b] = in0+in1, IN_WIDTH+1 bits, no overflow.
//  - edge n+1: W[b] = sum of the last WINDOW S values, WSUM_WIDTH bits.
//    Implement as W += S_new - S_oldest using a WINDOW-deep S shift register.
//    WINDOW=1: W = S.
//  - edge n+2: hit[b] = (W[b] > {0,active[b]}). Strict: equal does NOT trigger.
//  - An input sampled at edge n first affects trigger_o after edge n+2.
//  Thresholds
//  - thresh_wr_i with thresh_addr_i < NBEAMS writes staging at the edge; addr >= NBEAMS is ignored.
//  - update_i: active[b] <= staging[b] for all b, at the edge.
//  - wr and update in the same cycle: active gets the pre-write staging value; the new value needs a later update.
//  - The compare uses active[b] as registered at the same edge as W. A new threshold affects trigger_o one edge after update_i.
//  Holdoff
//  - HOLDOFF = 0: trigger_o[b] = hit[b] every cycle (level).
//  - HOLDOFF > 0: per-beam FSM with states IDLE and HOLD.
//    IDLE & hit: trigger_o[b]=1 for one cycle; load cnt=HOLDOFF; go to HOLD.
//    HOLD: trigger_o[b]=0, cnt decrements; go to IDLE when cnt reaches 0.
//    A hit on the cycle cnt reaches 0 is ignored; the first trigger can be the next cycle.
//  - Beams are fully independent; updates and writes never disturb window or holdoff state.
// TESTING (NBEAMS=2, IN_WIDTH=17, THRESH_WIDTH=18, WINDOW=2 unless noted)
//  1 Equality vs. exceed:
//    thresh0=80000 written + updated; beam0 in0=in1=20000 held -> W=80000, trigger_o[0]=0.
//    in0 -> 20001 for one sample -> trigger_o[0]=1 exactly 2 cycles (WINDOW) starting 3 edges after the change.
//  2 Staging vs. active:
//    write thresh1=10 without update, inputs 100 -> no trigger.
//    Pulse update_i -> trigger_o[1] rises one edge later.
//    Write and update in the same cycle -> old staged value takes effect.
//  3 Bad address: thresh_addr_i=3 with NBEAMS=3 -> no staging entry changes.
//  4 Holdoff: HOLDOFF=4, W held above threshold -> trigger_o pulses 1 cycle every 5 cycles.
//  5 Width extremes: WINDOW=4, all inputs 131071, thresh all ones (262143) -> W=1048568 with no wrap, trigger=1.
//  6 Reset mid-stream: assert rst_ni low while triggering -> trigger_o=0 immediately (async).
//    After release -> thresholds all ones, no trigger until thresholds are rewritten and updated.

Source files
------------

// File: rtl/multi_beam_thresh.sv
// multi_beam_thresh: N-beam threshold trigger for the beamformer back end.
// Each beam adds its two inputs, keeps a running sum over the last WINDOW
// samples and fires when that sum strictly exceeds the beam's active
// threshold. Thresholds are staged one at a time and committed together.
// An optional holdoff limits how often each beam can fire.
module multi_beam_thresh #(
    parameter int NBEAMS       = 2,
    parameter int IN_WIDTH     = 17,
    parameter int THRESH_WIDTH = 18,
    parameter int WINDOW       = 2,
    parameter int HOLDOFF      = 0,
    localparam int AW          = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
    localparam int WSUM_WIDTH  = IN_WIDTH + 1 + $clog2(WINDOW)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NBEAMS*IN_WIDTH-1:0] beam_in0_i,
    input  logic [NBEAMS*IN_WIDTH-1:0] beam_in1_i,
    input  logic [THRESH_WIDTH-1:0]    thresh_i,
    input  logic [AW-1:0]              thresh_addr_i,
    input  logic                       thresh_wr_i,
    input  logic                       update_i,
    output logic [NBEAMS-1:0]          trigger_o
);

    localparam int SW = IN_WIDTH + 1;

    logic [THRESH_WIDTH-1:0] stagingReg [NBEAMS];
    logic [THRESH_WIDTH-1:0] activeReg  [NBEAMS];

    // Threshold banks: writes land in staging (addresses past the last beam
    // match no entry and are dropped); update copies the pre-write staging
    // values into the active bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NBEAMS; b++) begin
                stagingReg[b] <= '1;
                activeReg[b]  <= '1;
            end
        end else begin
            for (int b = 0; b < NBEAMS; b++) begin
                if (update_i) begin
                    activeReg[b] <= stagingReg[b];
                end
                if (thresh_wr_i && (thresh_addr_i == AW'(b))) begin
                    stagingReg[b] <= thresh_i;
                end
            end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < NBEAMS; gb++) begin : gBeam
            logic [SW-1:0]         sumReg;
            logic [SW-1:0]         histReg [WINDOW];
            logic [WSUM_WIDTH-1:0] winReg;
            logic                  hit;
            logic                  trigReg;

            // First stage: pair sum, one bit wider so it never overflows.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sumReg <= '0;
                end else begin
                    sumReg <= SW'(beam_in0_i[gb*IN_WIDTH +: IN_WIDTH])
                            + SW'(beam_in1_i[gb*IN_WIDTH +: IN_WIDTH]);
                end
            end

            // Second stage: running window sum. The history holds exactly the
            // samples currently in the window, so adding the newest and
            // dropping the oldest keeps winReg equal to their total (for
            // WINDOW=1 this reduces to winReg = sumReg).
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < WINDOW; k++) begin
                        histReg[k] <= '0;
                    end
                    winReg <= '0;
                end else begin
                    histReg[0] <= sumReg;
                    for (int k = 1; k < WINDOW; k++) begin
                        histReg[k] <= histReg[k-1];
                    end
                    winReg <= winReg + WSUM_WIDTH'(sumReg)
                            - WSUM_WIDTH'(histReg[WINDOW-1]);
                end
            end

            assign hit = (winReg > WSUM_WIDTH'(activeReg[gb]));

            if (HOLDOFF == 0) begin : gLevel
                // Free-running compare: the trigger simply follows the hit.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        trigReg <= 1'b0;
                    end else begin
                        trigReg <= hit;
                    end
                end
            end else begin : gHoldoff
                localparam int CW = $clog2(HOLDOFF + 1);

                typedef enum logic {
                    IDLE = 1'b0,
                    HOLD = 1'b1
                } holdState_e;

                holdState_e    state;
                holdState_e    stateNext;
                logic [CW-1:0] cnt;
                logic [CW-1:0] cntNext;
                logic          trigNext;

                // Holdoff state, counter and trigger registers.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        trigReg <= 1'b0;
                    end else begin
                        state   <= stateNext;
                        cnt     <= cntNext;
                        trigReg <= trigNext;
                    end
                end

                // Fire once on a hit, then ignore hits until the counter
                // runs out; the cycle it reaches zero is still ignored.
                always_comb begin
                    stateNext = state;
                    cntNext   = cnt;
                    trigNext  = 1'b0;
                    case (state)
                        IDLE: begin
                            if (hit) begin
                                trigNext  = 1'b1;
                                cntNext   = CW'(HOLDOFF);
                                stateNext = HOLD;
                            end
                        end
                        HOLD: begin
                            cntNext = cnt - CW'(1);
                            if (cnt == CW'(1)) begin
                                stateNext = IDLE;
                            end
                        end
                        default: begin
                            stateNext = IDLE;
                            cntNext   = '0;
                        end
                    endcase
                end
            end

            assign trigger_o[gb] = trigReg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_beam_thresh.sv
// tb_multi_beam_thresh: directed bench for multi_beam_thresh. dutA uses the
// default parameters (level compare), dutB uses three beams, a four-sample
// window and a holdoff of four cycles.
module tb_multi_beam_thresh;

    logic        clk = 1'b0;
    logic        rstnA;
    logic        rstnB;

    logic [33:0] inA0;
    logic [33:0] inA1;
    logic [17:0] threshA;
    logic        addrA;
    logic        wrA;
    logic        updA;
    logic [1:0]  trigA;

    logic [50:0] inB0;
    logic [50:0] inB1;
    logic [17:0] threshB;
    logic [1:0]  addrB;
    logic        wrB;
    logic        updB;
    logic [2:0]  trigB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_beam_thresh #(
        .NBEAMS(2), .IN_WIDTH(17), .THRESH_WIDTH(18), .WINDOW(2), .HOLDOFF(0)
    ) dutA (
        .clk_i(clk), .rst_ni(rstnA),
        .beam_in0_i(inA0), .beam_in1_i(inA1),
        .thresh_i(threshA), .thresh_addr_i(addrA),
        .thresh_wr_i(wrA), .update_i(updA),
        .trigger_o(trigA)
    );

    multi_beam_thresh #(
        .NBEAMS(3), .IN_WIDTH(17), .THRESH_WIDTH(18), .WINDOW(4), .HOLDOFF(4)
    ) dutB (
        .clk_i(clk), .rst_ni(rstnB),
        .beam_in0_i(inB0), .beam_in1_i(inB1),
        .thresh_i(threshB), .thresh_addr_i(addrB),
        .thresh_wr_i(wrB), .update_i(updB),
        .trigger_o(trigB)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int beam, input logic [16:0] v0,
                                 input logic [16:0] v1);
        inA0[beam*17 +: 17] = v0;
        inA1[beam*17 +: 17] = v1;
    endtask

    task automatic writeThreshA(input logic addr, input logic [17:0] val);
        wrA     = 1'b1;
        addrA   = addr;
        threshA = val;
        tick(1);
        wrA     = 1'b0;
    endtask

    task automatic updateA();
        updA = 1'b1;
        tick(1);
        updA = 1'b0;
    endtask

    initial begin
        rstnA = 1'b0; rstnB = 1'b0;
        inA0 = '0; inA1 = '0; threshA = '0; addrA = 1'b0; wrA = 1'b0; updA = 1'b0;
        inB0 = '0; inB1 = '0; threshB = '0; addrB = '0; wrB = 1'b0; updB = 1'b0;
        tick(2);
        checkOutput("resetA", 8'(trigA), 8'h00);
        checkOutput("resetB", 8'(trigB), 8'h00);
        rstnA = 1'b1; rstnB = 1'b1;
        tick(1);

        // Equality does not trigger; a one-sample excess shows for WINDOW cycles.
        $display("[TB] equality vs exceed");
        applyStimulus(0, 17'd20000, 17'd20000);
        writeThreshA(1'b0, 18'd80000);
        updateA();
        tick(6);
        checkOutput("eqNoTrig", 8'(trigA), 8'h00);
        applyStimulus(0, 17'd20001, 17'd20000);
        tick(1);
        applyStimulus(0, 17'd20000, 17'd20000);
        checkOutput("exceedN1", 8'(trigA), 8'h00);
        tick(1);
        checkOutput("exceedN2", 8'(trigA), 8'h00);
        tick(1);
        checkOutput("exceedN3", 8'(trigA), 8'h01);
        tick(1);
        checkOutput("exceedN4", 8'(trigA), 8'h01);
        tick(1);
        checkOutput("exceedN5", 8'(trigA), 8'h00);

        // Staged thresholds only take effect after an update.
        $display("[TB] staging vs active");
        applyStimulus(1, 17'd100, 17'd100);
        writeThreshA(1'b1, 18'd10);
        tick(5);
        checkOutput("stagedOnly", 8'(trigA), 8'h00);
        updA = 1'b1;
        tick(1);
        updA = 1'b0;
        checkOutput("updN1", 8'(trigA), 8'h00);
        tick(1);
        checkOutput("updN2", 8'(trigA), 8'h02);
        wrA = 1'b1; addrA = 1'b1; threshA = 18'd1000; updA = 1'b1;
        tick(1);
        wrA = 1'b0; updA = 1'b0;
        tick(2);
        checkOutput("wrUpdSame", 8'(trigA), 8'h02);
        updateA();
        checkOutput("lateUpdN1", 8'(trigA), 8'h02);
        tick(1);
        checkOutput("lateUpdN2", 8'(trigA), 8'h00);
        writeThreshA(1'b1, 18'd10);
        updateA();
        tick(1);
        checkOutput("rearm", 8'(trigA), 8'h02);

        // Asynchronous reset while beam 1 is triggering.
        $display("[TB] reset mid-stream");
        rstnA = 1'b0;
        #1;
        checkOutput("asyncReset", 8'(trigA), 8'h00);
        tick(2);
        rstnA = 1'b1;
        tick(8);
        checkOutput("postResetNoTrig", 8'(trigA), 8'h00);
        writeThreshA(1'b1, 18'd10);
        updateA();
        tick(1);
        checkOutput("rewritten", 8'(trigA), 8'h02);

        // Out-of-range address on the three-beam instance changes nothing.
        $display("[TB] bad address");
        inB0 = {3{17'd1000}};
        inB1 = {3{17'd1000}};
        tick(6);
        wrB = 1'b1; addrB = 2'd3; threshB = 18'd5;
        tick(1);
        wrB = 1'b0; updB = 1'b1;
        tick(1);
        updB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("badAddr", 8'(trigB), 8'h00);
        end

        // Holdoff of four cycles: beam 0 fires once every five cycles.
        $display("[TB] holdoff");
        wrB = 1'b1; addrB = 2'd0; threshB = 18'd5000;
        tick(1);
        wrB = 1'b0; updB = 1'b1;
        tick(1);
        updB = 1'b0;
        checkOutput("holdPre", 8'(trigB), 8'h00);
        tick(1);
        checkOutput("holdFire", 8'(trigB), 8'h01);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                tick(1);
                checkOutput("holdQuiet", 8'(trigB), 8'h00);
            end
            tick(1);
            checkOutput("holdRefire", 8'(trigB), 8'h01);
        end

        // Full-scale inputs against all-ones thresholds after a reset.
        $display("[TB] width extremes");
        rstnB = 1'b0;
        inB0 = {3{17'h1FFFF}};
        inB1 = {3{17'h1FFFF}};
        tick(2);
        rstnB = 1'b1;
        tick(3);
        checkOutput("wideR3", 8'(trigB), 8'h00);
        tick(1);
        checkOutput("wideFire", 8'(trigB), 8'h07);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("wideQuiet", 8'(trigB), 8'h00);
        end
        tick(1);
        checkOutput("wideRefire", 8'(trigB), 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
